video_pixel_shifter: RTL and testbench

Downstream stage of `video_gen`. It captures the character code and glyph pattern bytes that `video_gen` fetches over the shared bus. It serializes each 8-pixel glyph row MSB-first at the pixel rate, applies reverse video from bit 7 of the character code, and blanks output outside the active area. A single-slot pipeline decouples bus fetch timing from the shift-out boundary, and a sticky flag reports late fetches.

---
 rtl/video_pkg.sv | 16 +
 rtl/video_fetch_slot.sv | 52 +++++
 rtl/video_pixel_shifter.sv | 127 ++++++++++++
 tb/tb_video_pixel_shifter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared constants for the character video path.
// Used by video_gen and video_pixel_shifter.
package video_pkg;

  localparam int PIXELS_PER_CHAR  = 8;
  localparam int REVERSE_BIT      = 7;
  localparam int ACTIVE_DELAY_DEF = 8;

  typedef struct packed {
    logic       code_rev;
    logic [7:0] pattern;
    logic       code_valid;
    logic       pattern_valid;
  } fetch_slot_t;

endpackage

// File: rtl/video_fetch_slot.sv
// Single-slot holding buffer for one character fetch.
// Decouples bus fetch timing from the shift-out boundary.
module video_fetch_slot
  import video_pkg::*;
(
  input  logic       pixel_clk_i,
  input  logic       reset_i,
  input  logic [7:0] bus_data,
  input  logic       ram_load,
  input  logic       rom_load,
  input  logic       consume,
  output logic       code_rev,
  output logic [7:0] pattern,
  output logic       pattern_valid
);

  fetch_slot_t slot_q;

  logic rom_take;

  // The ROM byte belongs to the pending code; once that code is
  // consumed (or displaced by a new RAM fetch) the byte is dropped.
  assign rom_take = rom_load
                  & slot_q.code_valid
                  & ~consume
                  & ~ram_load;

  // Capture code/pattern; consume first, then a new code refills.
  always_ff @(posedge pixel_clk_i) begin
    if (reset_i) begin
      slot_q <= '0;
    end else begin
      if (consume) begin
        slot_q.code_valid    <= 1'b0;
        slot_q.pattern_valid <= 1'b0;
      end
      if (ram_load) begin
        slot_q.code_rev      <= bus_data[REVERSE_BIT];
        slot_q.code_valid    <= 1'b1;
        slot_q.pattern_valid <= 1'b0;
      end else if (rom_take) begin
        slot_q.pattern       <= bus_data;
        slot_q.pattern_valid <= 1'b1;
      end
    end
  end

  assign code_rev      = slot_q.code_rev;
  assign pattern       = slot_q.pattern;
  assign pattern_valid = slot_q.pattern_valid;

endmodule

// File: rtl/video_pixel_shifter.sv
// Glyph row serializer with reverse video and active blanking.
// Flags character boundaries reached without a completed fetch.
module video_pixel_shifter
  import video_pkg::*;
#(
  parameter int PIXELS_PER_CHAR = video_pkg::PIXELS_PER_CHAR,
  parameter int ACTIVE_DELAY    = video_pkg::ACTIVE_DELAY_DEF
) (
  input  logic       pixel_clk_i,
  input  logic       reset_i,
  input  logic [7:0] bus_data_i,
  input  logic       ram_load_i,
  input  logic       rom_load_i,
  input  logic       char_start_i,
  input  logic       h_active_i,
  input  logic       v_active_i,
  input  logic       reverse_en_i,
  output logic       video_o,
  output logic       late_fetch_o,
  input  logic       late_clear_i
);

  localparam int W   = PIXELS_PER_CHAR;
  localparam int PXW = (W > 1) ? $clog2(W) : 1;

  logic [PXW-1:0]          px;
  logic [W-1:0]            shift_q;
  logic                    rev_q;
  logic [ACTIVE_DELAY-1:0] active_pipe;

  logic       code_rev;
  logic [7:0] pattern;
  logic       pattern_valid;
  logic       load_evt;
  logic       consume;
  logic       active_in;
  logic       cell_active;

  assign active_in = h_active_i & v_active_i;

  assign load_evt = char_start_i
                  | (px == PXW'(W - 1));

  assign consume = load_evt & pattern_valid;

  // cell_active is the active bit that gates the cell's first pixel.
  generate
    if (ACTIVE_DELAY > 1) begin : g_deep
      assign cell_active = active_pipe[ACTIVE_DELAY-2];
    end else begin : g_shallow
      assign cell_active = active_in;
    end
  endgenerate

  video_fetch_slot u_slot (
    .pixel_clk_i   (pixel_clk_i),
    .reset_i       (reset_i),
    .bus_data      (bus_data_i),
    .ram_load      (ram_load_i),
    .rom_load      (rom_load_i),
    .consume       (consume),
    .code_rev      (code_rev),
    .pattern       (pattern),
    .pattern_valid (pattern_valid)
  );

  // Pixel counter: restarts on char_start, otherwise free-runs.
  always_ff @(posedge pixel_clk_i) begin
    if (reset_i) begin
      px <= '0;
    end else if (char_start_i || px == PXW'(W - 1)) begin
      px <= '0;
    end else begin
      px <= px + PXW'(1);
    end
  end

  // Delay active so it lines up with the serialized pixel.
  always_ff @(posedge pixel_clk_i) begin
    if (reset_i) begin
      active_pipe <= '0;
    end else if (ACTIVE_DELAY > 1) begin
      active_pipe <= {active_pipe[ACTIVE_DELAY-2:0], active_in};
    end else begin
      active_pipe <= ACTIVE_DELAY'(active_in);
    end
  end

  // Shifter: reload at the cell boundary, else shift MSB-first.
  always_ff @(posedge pixel_clk_i) begin
    if (reset_i) begin
      shift_q <= '0;
      rev_q   <= 1'b0;
    end else if (load_evt && pattern_valid) begin
      shift_q <= W'(pattern);
      rev_q   <= code_rev & reverse_en_i;
    end else if (load_evt) begin
      shift_q <= '0;
      rev_q   <= 1'b0;
    end else begin
      shift_q <= {shift_q[W-2:0], 1'b0};
    end
  end

  // Sticky late flag; a new late condition beats a clear.
  always_ff @(posedge pixel_clk_i) begin
    if (reset_i) begin
      late_fetch_o <= 1'b0;
    end else if (load_evt && !pattern_valid && cell_active) begin
      late_fetch_o <= 1'b1;
    end else if (late_clear_i) begin
      late_fetch_o <= 1'b0;
    end
  end

  // Registered pixel; blanked pixels stay dark even when reversed.
  always_ff @(posedge pixel_clk_i) begin
    if (reset_i) begin
      video_o <= 1'b0;
    end else if (active_pipe[ACTIVE_DELAY-1]) begin
      video_o <= shift_q[W-1] ^ rev_q;
    end else begin
      video_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_pixel_shifter.sv
// Directed bench for video_pixel_shifter.
// Inputs change and outputs are sampled on the falling edge.
module tb_video_pixel_shifter;

  logic       clk;
  logic       reset;
  logic [7:0] bus_data;
  logic       ram_load;
  logic       rom_load;
  logic       char_start;
  logic       h_active;
  logic       v_active;
  logic       reverse_en;
  logic       video;
  logic       late_fetch;
  logic       late_clear;

  int total = 0;
  int bad   = 0;

  video_pixel_shifter dut (
    .pixel_clk_i  (clk),
    .reset_i      (reset),
    .bus_data_i   (bus_data),
    .ram_load_i   (ram_load),
    .rom_load_i   (rom_load),
    .char_start_i (char_start),
    .h_active_i   (h_active),
    .v_active_i   (v_active),
    .reverse_en_i (reverse_en),
    .video_o      (video),
    .late_fetch_o (late_fetch),
    .late_clear_i (late_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  // Fetch code then pattern, start the cell, check 8 pixels.
  task automatic run_cell(input string tag, input logic [7:0] code,
                          input logic [7:0] pat,
                          input logic [7:0] exp);
    bus_data = code;
    ram_load = 1'b1;
    nxt();
    ram_load = 1'b0;
    bus_data = pat;
    rom_load = 1'b1;
    nxt();
    rom_load = 1'b0;
    char_start = 1'b1;
    nxt();
    char_start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      nxt();
      chk($sformatf("%s px%0d", tag, k - 1), video, exp[8-k]);
    end
  endtask

  initial begin
    reset      = 1'b1;
    bus_data   = 8'h00;
    ram_load   = 1'b0;
    rom_load   = 1'b0;
    char_start = 1'b0;
    h_active   = 1'b1;
    v_active   = 1'b1;
    reverse_en = 1'b0;
    late_clear = 1'b0;
    repeat (2) nxt();
    chk("reset video", video, 1'b0);
    chk("reset late", late_fetch, 1'b0);
    reset = 1'b0;
    repeat (10) nxt();

    run_cell("a5", 8'h01, 8'hA5, 8'hA5);
    reverse_en = 1'b1;
    run_cell("rev_on", 8'h81, 8'hF0, 8'h0F);
    reverse_en = 1'b0;
    run_cell("rev_off", 8'h81, 8'hF0, 8'hF0);

    v_active = 1'b0;
    repeat (10) nxt();
    late_clear = 1'b1;
    nxt();
    late_clear = 1'b0;
    chk("blank pre late", late_fetch, 1'b0);
    run_cell("blank", 8'h81, 8'hFF, 8'h00);
    chk("blank late", late_fetch, 1'b0);
    char_start = 1'b1;
    nxt();
    char_start = 1'b0;
    nxt();
    chk("blank nofetch late", late_fetch, 1'b0);

    v_active = 1'b1;
    repeat (10) nxt();
    char_start = 1'b1;
    nxt();
    char_start = 1'b0;
    late_clear = 1'b1;
    nxt();
    late_clear = 1'b0;
    chk("late cleared", late_fetch, 1'b0);
    char_start = 1'b1;
    nxt();
    char_start = 1'b0;
    chk("late set", late_fetch, 1'b1);
    for (int k = 0; k < 3; k++) begin
      nxt();
      chk($sformatf("late px%0d", k), video, 1'b0);
    end
    late_clear = 1'b1;
    nxt();
    late_clear = 1'b0;
    chk("late clear", late_fetch, 1'b0);
    char_start = 1'b1;
    late_clear = 1'b1;
    nxt();
    char_start = 1'b0;
    late_clear = 1'b0;
    chk("set beats clear", late_fetch, 1'b1);

    late_clear = 1'b1;
    ram_load   = 1'b1;
    rom_load   = 1'b1;
    bus_data   = 8'hFF;
    nxt();
    late_clear = 1'b0;
    ram_load   = 1'b0;
    rom_load   = 1'b0;
    chk("ramrom pre late", late_fetch, 1'b0);
    char_start = 1'b1;
    nxt();
    char_start = 1'b0;
    chk("ramrom late", late_fetch, 1'b1);
    for (int k = 0; k < 4; k++) begin
      nxt();
      chk($sformatf("ramrom px%0d", k), video, 1'b0);
    end

    bus_data = 8'h01;
    ram_load = 1'b1;
    nxt();
    ram_load = 1'b0;
    bus_data = 8'hFF;
    rom_load = 1'b1;
    nxt();
    rom_load = 1'b0;
    char_start = 1'b1;
    nxt();
    char_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      nxt();
      chk($sformatf("prereset px%0d", k), video, 1'b1);
    end
    reset = 1'b1;
    nxt();
    chk("midreset video", video, 1'b0);
    chk("midreset late", late_fetch, 1'b0);
    reset = 1'b0;
    repeat (10) nxt();
    run_cell("post", 8'h02, 8'h3C, 8'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
